// File: rtl/operand_sequencer.sv
// Operand entry front-end for the 4-bit adder: synchronizes and debounces two buttons and sequences A/B capture.
// Optional `OPERAND_SEQ_LIVE_PREVIEW_EN` lets the field being entered follow SWITCH combinationally.
module operand_seq_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       s1, s2, acc, acc_d, rdy, armed;
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      acc   <= 1'b0;
      acc_d <= 1'b0;
      rdy   <= 1'b0;
      armed <= 1'b0;
      cnt   <= 8'd0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      acc_d <= acc;
      rdy   <= 1'b1;
      // a button held through reset must be seen released before it may pulse
      if (rdy && !s1) armed <= 1'b1;
      if (s2 == acc) cnt <= 8'd0;
      else if (cnt == LAST) begin
        acc <= ~acc;
        cnt <= 8'd0;
      end else cnt <= cnt + 8'd1;
    end
  end

  assign press = acc & ~acc_d & armed;
endmodule

module operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] SWITCH,
  input  logic       btn_next,
  input  logic       btn_clear,
  output logic [7:0] operands,
  output logic [1:0] state,
  output logic       valid,
  output logic [7:0] pair_count
);
  localparam int NUM_BTN = 2;
  localparam int NXT = 0;
  localparam int CLR = 1;

  localparam logic [1:0] WAIT_A = 2'd0;
  localparam logic [1:0] WAIT_B = 2'd1;
  localparam logic [1:0] SHOW   = 2'd2;

  logic [NUM_BTN-1:0] btn_raw, press;
  logic [3:0]         a_reg, b_reg;

  assign btn_raw = {btn_clear, btn_next};

  genvar g;
  generate
    for (g = 0; g < NUM_BTN; g++) begin : g_btn
      operand_seq_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_raw[g]),
        .press(press[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_A;
      valid      <= 1'b0;
      a_reg      <= 4'h0;
      b_reg      <= 4'h0;
      pair_count <= 8'd0;
    end else if (press[CLR]) begin
      state <= WAIT_A;
      valid <= 1'b0;
      a_reg <= 4'h0;
      b_reg <= 4'h0;
    end else if (press[NXT]) begin
      case (state)
        WAIT_A: begin
          a_reg <= SWITCH;
          state <= WAIT_B;
          valid <= 1'b0;
        end
        WAIT_B: begin
          b_reg      <= SWITCH;
          state      <= SHOW;
          valid      <= 1'b1;
          pair_count <= pair_count + 8'd1;
        end
        SHOW: begin
          a_reg <= SWITCH;
          b_reg <= 4'h0;
          state <= WAIT_B;
          valid <= 1'b0;
        end
        default: begin
          state <= WAIT_A;
          valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef OPERAND_SEQ_LIVE_PREVIEW_EN
  always_comb begin
    operands = {b_reg, a_reg};
    case (state)
      WAIT_A:  operands = {b_reg, SWITCH};
      WAIT_B:  operands = {SWITCH, a_reg};
      default: operands = {b_reg, a_reg};
    endcase
  end
`else
  assign operands = {b_reg, a_reg};
`endif
endmodule

// File: tb/tb_operand_sequencer.sv
// Scoreboard bench for operand_sequencer: stimulus pushes expected output events, a monitor pops on each change.
module tb_operand_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] SWITCH = 4'h0;
  logic       btn_next = 1'b0;
  logic       btn_clear = 1'b0;
  logic [7:0] operands;
  logic [1:0] state;
  logic       valid;
  logic [7:0] pair_count;

  operand_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .SWITCH(SWITCH), .btn_next(btn_next), .btn_clear(btn_clear),
    .operands(operands), .state(state), .valid(valid), .pair_count(pair_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st;
    logic [7:0] ops;
    logic       v;
    logic [7:0] pc;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;

  logic [1:0] m_st = 2'd0;
  logic [3:0] m_a = 4'h0, m_b = 4'h0;
  logic [7:0] m_pc = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [7:0] model_ops(input logic [3:0] sw);
`ifdef OPERAND_SEQ_LIVE_PREVIEW_EN
    if (m_st == 2'd0) return {m_b, sw};
    if (m_st == 2'd1) return {sw, m_a};
`endif
    return {m_b, m_a};
  endfunction

  task automatic push_exp(input int c);
    exp_t e;
    e.st  = m_st;
    e.ops = model_ops(SWITCH);
    e.v   = (m_st == 2'd2);
    e.pc  = m_pc;
    e.cyc = c;
    q.push_back(e);
  endtask

  task automatic model_next();
    case (m_st)
      2'd0: begin m_a = SWITCH; m_st = 2'd1; end
      2'd1: begin m_b = SWITCH; m_st = 2'd2; m_pc = m_pc + 8'd1; end
      default: begin m_a = SWITCH; m_b = 4'h0; m_st = 2'd1; end
    endcase
  endtask

  task automatic model_clear();
    m_a = 4'h0; m_b = 4'h0; m_st = 2'd0;
  endtask

  // press next at a negedge; raw is first sampled on the following edge
  task automatic press_next(input logic [3:0] sw, input bit check_lat, input int hold);
    @(negedge clk);
    SWITCH = sw;
    model_next();
    push_exp(check_lat ? cyc + 7 : -1);
    btn_next = 1'b1;
    repeat (hold) @(negedge clk);
    btn_next = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, q.size(), 0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_st = 2'd0; m_a = 4'h0; m_b = 4'h0; m_pc = 8'd0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
  endtask

  // Monitor: an output event is any change of the observed outputs
  initial begin
    logic [18:0] cur, prev;
    bit trig;
    exp_t e;
    prev = '0;
    forever begin
      @(posedge clk);
      #1;
      cur = {state, operands, valid, pair_count};
`ifdef OPERAND_SEQ_LIVE_PREVIEW_EN
      trig = (cur[18:17] != prev[18:17]) || (cur[7:0] != prev[7:0]);
`else
      trig = (cur != prev);
`endif
      if (mon_en && trig) begin
        if (q.size() == 0) begin
          chk("unexpected_event", {13'd0, cur}, {13'd0, prev});
        end else begin
          e = q.pop_front();
          chk("mon_state", 32'(state), 32'(e.st));
          chk("mon_operands", 32'(operands), 32'(e.ops));
          chk("mon_valid", 32'(valid), 32'(e.v));
          chk("mon_pair_count", 32'(pair_count), 32'(e.pc));
          if (e.cyc >= 0) chk("mon_latency", cyc, e.cyc);
        end
      end
      prev = cur;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_operands", 32'(operands), 32'h00);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_pair_count", 32'(pair_count), 32'd0);
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    // basic pair: A = 9 with latency check, then B = 8
    press_next(4'h9, 1'b1, 10);
    drain("basic_a_drain");
    press_next(4'h8, 1'b0, 10);
    drain("basic_b_drain");
    chk("basic_operands", 32'(operands), 32'h89);
    chk("basic_sum", 32'((operands[3:0] + operands[7:4]) & 4'hF), 32'h1);

    // clear and next rising together: clear wins
    @(negedge clk);
    model_clear();
    push_exp(-1);
    btn_clear = 1'b1;
    btn_next  = 1'b1;
    repeat (10) @(negedge clk);
    btn_clear = 1'b0;
    btn_next  = 1'b0;
    repeat (10) @(negedge clk);
    drain("clear_prio_drain");
    chk("clear_prio_state", 32'(state), 32'd0);
    chk("clear_prio_operands", 32'(operands), 32'h00);
    chk("clear_prio_pair_count", 32'(pair_count), 32'd1);

    // bounce: 3 high / 1 low, five times, must not register
    SWITCH = 4'h5;
    for (int i = 0; i < 5; i++) begin
      btn_next = 1'b1;
      repeat (3) @(negedge clk);
      btn_next = 1'b0;
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    chk("bounce_state", 32'(state), 32'd0);
    press_next(4'h5, 1'b0, 20);
    drain("bounce_hold_drain");
    chk("bounce_operands", 32'(operands), 32'h05);

    // plain clear from WAIT_B
    @(negedge clk);
    model_clear();
    push_exp(-1);
    btn_clear = 1'b1;
    repeat (8) @(negedge clk);
    btn_clear = 1'b0;
    repeat (8) @(negedge clk);
    drain("clear_drain");

    // wrap: 255 more pairs bring the total to 256
    for (int i = 0; i < 255; i++) begin
      press_next(4'(i), 1'b0, 8);
      press_next(4'(i + 3), 1'b0, 8);
    end
    drain("wrap_drain");
    chk("wrap_pair_count", 32'(pair_count), 32'd0);
    chk("wrap_valid", 32'(valid), 32'd1);

    // button held through reset must be released before it counts
    @(negedge clk);
    btn_next = 1'b1;
    do_reset();
    repeat (20) @(negedge clk);
    chk("held_state", 32'(state), 32'd0);
    btn_next = 1'b0;
    repeat (10) @(negedge clk);
    chk("held_release_state", 32'(state), 32'd0);
    press_next(4'h3, 1'b0, 10);
    drain("held_repress_drain");
    chk("held_repress_operands", 32'(operands), 32'h03);

    // switch sweep in WAIT_A
    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      SWITCH = 4'(i);
      #1;
      chk("sweep_operands", 32'(operands), 32'(model_ops(SWITCH)));
    end
    chk("sweep_state", 32'(state), 32'd0);

    repeat (4) @(negedge clk);
    drain("final_drain");
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
